// File: rtl/dec_scoreboard.sv
// Register-dependency scoreboard for the decode stage: counts pending writes per
// general register and holds dec_ready_go low while a source is still owed a write.
module dec_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_valid,
  input  logic [4:0] dec_rj,
  input  logic       dec_rj_used,
  input  logic [4:0] dec_rkd,
  input  logic       dec_rkd_used,
  input  logic [4:0] dec_dest,
  input  logic       dec_gr_we,
  input  logic       dec_fire,
  input  logic       wb_valid,
  input  logic       wb_we,
  input  logic [4:0] wb_dest,
  output logic       dec_ready_go,
  output logic       sb_busy,
  output logic [2:0] inflight,
  output logic       sb_err
);

  // Exact running total of all counters; inflight is its saturated view, so the
  // reported value stays correct after the total drops back below 7.
  localparam int TOT_W = $clog2(31 * MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [TOT_W-1:0] total_q, total_d;
  logic             err_q, err_d;

  logic inc_ev, dec_ev, same_reg;
  logic hazard_rj, hazard_rkd;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    inc_ev   = dec_fire & dec_gr_we & (dec_dest != 5'd0);
    dec_ev   = wb_valid & wb_we & (wb_dest != 5'd0);
    same_reg = inc_ev & dec_ev & (dec_dest == wb_dest);

    cnt_d   = cnt_q;
    total_d = total_q;
    err_d   = err_q;

    // A simultaneous issue and retire of the same register cancel out.
    if (!same_reg) begin
      if (inc_ev) begin
        if (cnt_q[dec_dest] == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[dec_dest] = cnt_q[dec_dest] + CNT_W'(1);
          total_d         = total_d + TOT_W'(1);
        end
      end
      if (dec_ev) begin
        if (cnt_q[wb_dest] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[wb_dest] = cnt_q[wb_dest] - CNT_W'(1);
          total_d        = total_d - TOT_W'(1);
        end
      end
    end

    cnt_d[0] = '0;
  end

  // NOTE: the counter array is reset, unlike a data RAM: stale counts would
  // stall decode forever or hide a real hazard after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
      total_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      cnt_q   <= cnt_d;
      total_q <= total_d;
      err_q   <= err_d;
    end
  end

  // Hazards look only at registered counters: a retire in this cycle still stalls,
  // because the regfile write lands at the edge and there is no forwarding.
  assign hazard_rj    = dec_rj_used  & (dec_rj  != 5'd0) & (cnt_q[dec_rj]  != '0);
  assign hazard_rkd   = dec_rkd_used & (dec_rkd != 5'd0) & (cnt_q[dec_rkd] != '0);
  assign dec_ready_go = ~(dec_valid & (hazard_rj | hazard_rkd));

  assign sb_busy  = (total_q != '0);
  assign inflight = (total_q > TOT_W'(7)) ? 3'd7 : total_q[2:0];
  assign sb_err   = err_q;

endmodule

// File: tb/tb_dec_scoreboard.sv
// Self-checking bench for dec_scoreboard: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a reference model.
module tb_dec_scoreboard;

  localparam int MAX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_rj_used, dec_rkd_used, dec_gr_we, dec_fire;
  logic [4:0] dec_rj, dec_rkd, dec_dest;
  logic       wb_valid, wb_we;
  logic [4:0] wb_dest;
  logic       dec_ready_go, sb_busy, sb_err;
  logic [2:0] inflight;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending-write count per register and sticky error.
  int m_cnt [32];
  bit m_err;
  bit m_inc, m_dec;

  dec_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .dec_valid    (dec_valid),
    .dec_rj       (dec_rj),
    .dec_rj_used  (dec_rj_used),
    .dec_rkd      (dec_rkd),
    .dec_rkd_used (dec_rkd_used),
    .dec_dest     (dec_dest),
    .dec_gr_we    (dec_gr_we),
    .dec_fire     (dec_fire),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_dest      (wb_dest),
    .dec_ready_go (dec_ready_go),
    .sb_busy      (sb_busy),
    .inflight     (inflight),
    .sb_err       (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the issue/retire rules to the plain array.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_err = 1'b0;
    end else begin
      m_inc = dec_fire && dec_gr_we && (dec_dest != 0);
      m_dec = wb_valid && wb_we && (wb_dest != 0);
      if (!(m_inc && m_dec && dec_dest == wb_dest)) begin
        if (m_inc) begin
          if (m_cnt[dec_dest] == MAX) m_err = 1'b1;
          else m_cnt[dec_dest] = m_cnt[dec_dest] + 1;
        end
        if (m_dec) begin
          if (m_cnt[wb_dest] == 0) m_err = 1'b1;
          else m_cnt[wb_dest] = m_cnt[wb_dest] - 1;
        end
      end
    end
  end

  function automatic int m_sum();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic bit m_ready();
    bit hz_j, hz_k;
    hz_j = dec_rj_used  && dec_rj  != 0 && m_cnt[dec_rj]  > 0;
    hz_k = dec_rkd_used && dec_rkd != 0 && m_cnt[dec_rkd] > 0;
    return !(dec_valid && (hz_j || hz_k));
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int s;
    s = m_sum();
    check("cmp_ready",    8'(dec_ready_go), 8'(m_ready()));
    check("cmp_busy",     8'(sb_busy),      8'(s != 0));
    check("cmp_inflight", 8'(inflight),     8'(s > 7 ? 7 : s));
    check("cmp_err",      8'(sb_err),       8'(m_err));
  end

  task automatic idle();
    dec_valid = 0; dec_rj = 0; dec_rj_used = 0; dec_rkd = 0; dec_rkd_used = 0;
    dec_dest = 0; dec_gr_we = 0; dec_fire = 0;
    wb_valid = 0; wb_we = 0; wb_dest = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fire(input logic [4:0] d);
    dec_valid = 1; dec_gr_we = 1; dec_dest = d; dec_fire = 1;
  endtask

  task automatic retire(input logic [4:0] d);
    wb_valid = 1; wb_we = 1; wb_dest = d;
  endtask

  task automatic reader(input logic [4:0] rj, input bit rj_u, input logic [4:0] rk, input bit rk_u);
    dec_valid = 1; dec_rj = rj; dec_rj_used = rj_u; dec_rkd = rk; dec_rkd_used = rk_u;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 reset = 1;
    @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check("rst_ready",    8'(dec_ready_go), 8'd1);
    check("rst_busy",     8'(sb_busy),      8'd0);
    check("rst_inflight", 8'(inflight),     8'd0);
    check("rst_err",      8'(sb_err),       8'd0);

    // Underflow from reset.
    step(); retire(5'd2);
    step(); idle();
    @(negedge clk);
    check("underflow_err",      8'(sb_err),   8'd1);
    check("underflow_inflight", 8'(inflight), 8'd0);
    pulse_reset();

    // Back-to-back RAW: 3-cycle stall, retire in cycle 3 does not release yet.
    step(); fire(5'd4);
    step(); idle(); reader(5'd4, 1, 5'd0, 1);
    @(negedge clk);
    check("raw_stall1",   8'(dec_ready_go), 8'd0);
    check("raw_inflight", 8'(inflight),     8'd1);
    step();
    @(negedge clk);
    check("raw_stall2", 8'(dec_ready_go), 8'd0);
    step(); retire(5'd4);
    @(negedge clk);
    check("raw_stall3", 8'(dec_ready_go), 8'd0);
    step(); wb_valid = 0; wb_we = 0;
    @(negedge clk);
    check("raw_release", 8'(dec_ready_go), 8'd1);
    check("raw_drained", 8'(sb_busy),      8'd0);

    // No hazard: write r7, read r8 and r0.
    step(); idle(); fire(5'd7);
    step(); idle(); reader(5'd8, 1, 5'd0, 1);
    @(negedge clk);
    check("nohaz_ready",    8'(dec_ready_go), 8'd1);
    check("nohaz_inflight", 8'(inflight),     8'd1);
    step(); idle(); retire(5'd7);

    // Same-register inc and dec in one cycle.
    step(); idle(); fire(5'd3);
    step(); retire(5'd3);
    step(); idle(); reader(5'd3, 1, 5'd0, 0);
    @(negedge clk);
    check("same_inflight", 8'(inflight),     8'd1);
    check("same_err",      8'(sb_err),       8'd0);
    check("same_cnt_held", 8'(dec_ready_go), 8'd0);
    step(); idle(); retire(5'd3);

    // Store/branch second source.
    step(); idle(); fire(5'd6);
    step(); idle(); reader(5'd0, 0, 5'd6, 1);
    @(negedge clk);
    check("st_stall", 8'(dec_ready_go), 8'd0);
    #1 dec_rkd_used = 0;
    #1 check("st_unused", 8'(dec_ready_go), 8'd1);
    step(); dec_rkd_used = 1; retire(5'd6);
    @(negedge clk);
    check("st_retire_cycle", 8'(dec_ready_go), 8'd0);
    step(); wb_valid = 0; wb_we = 0;
    @(negedge clk);
    check("st_release", 8'(dec_ready_go), 8'd1);

    // Overflow: fourth issue to r9 saturates and flags.
    for (int i = 0; i < 4; i++) begin
      step(); idle(); fire(5'd9);
    end
    @(negedge clk);
    check("ovf_pre_err",  8'(sb_err),   8'd0);
    check("ovf_pre_cnt",  8'(inflight), 8'd3);
    step(); idle();
    @(negedge clk);
    check("ovf_err",      8'(sb_err),   8'd1);
    check("ovf_inflight", 8'(inflight), 8'd3);

    // Mid-cycle asynchronous reset with cnt[4] = 2.
    step(); fire(5'd4);
    step(); fire(5'd4);
    step(); idle(); reader(5'd4, 1, 5'd9, 1);
    @(negedge clk);
    check("pre_rst_inflight", 8'(inflight),     8'd5);
    check("pre_rst_ready",    8'(dec_ready_go), 8'd0);
    @(posedge clk);
    #3 reset = 1;
    #1;
    check("async_rst_ready",    8'(dec_ready_go), 8'd1);
    check("async_rst_busy",     8'(sb_busy),      8'd0);
    check("async_rst_inflight", 8'(inflight),     8'd0);
    check("async_rst_err",      8'(sb_err),       8'd0);
    @(posedge clk);
    #1 reset = 0;
    idle();

    // Randomized traffic, mostly legal retires, with one reset midway.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      idle();
      if (cyc == 1500) begin
        reset = 1;
        #2 reset = 0;
      end
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_rj       = 5'($urandom_range(0, 9));
      dec_rj_used  = 1'($urandom);
      dec_rkd      = 5'($urandom_range(0, 9));
      dec_rkd_used = 1'($urandom);
      dec_gr_we    = ($urandom_range(0, 3) != 0);
      dec_dest     = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
      dec_fire     = dec_valid && ($urandom_range(0, 2) != 0);
      wb_valid     = ($urandom_range(0, 2) != 0);
      wb_we        = ($urandom_range(0, 4) != 0);
      wb_dest      = 5'($urandom);
      if ($urandom_range(0, 9) < 8) begin
        int start;
        start = $urandom_range(1, 31);
        for (int k = 0; k < 31; k++) begin
          int r;
          r = 1 + (start - 1 + k) % 31;
          if (m_cnt[r] > 0) begin
            wb_dest = 5'(r);
            break;
          end
        end
      end
    end
    step(); idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_scoreboard.md
# dec_scoreboard

Register-dependency scoreboard that sequences the decode stage of the 5-stage LoongArch pipeline. It tracks, per general register, how many issued-but-not-retired instructions will write it. It withholds `dec_ready_go` while any source of the instruction in decode is still pending. It sits beside the decode stage, is updated by the decode→exe handshake and the write-back regfile port, and replaces the constant `decode_ready_go = 1`.

## Interface
- `CNT_W`, default 2: width of each per-register pending counter.
- `MAX_INFLIGHT`, default 3: largest legal counter value (EXE+MEM+WB occupancy); must be ≤ 2^CNT_W−1.
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `dec_valid` input 1: decode stage holds a valid instruction.
- `dec_rj` input 5: first source register number.
- `dec_rj_used` input 1: instruction reads `dec_rj`.
- `dec_rkd` input 5: second source register (rk, or rd for beq/bne/st.w).
- `dec_rkd_used` input 1: instruction reads `dec_rkd`.
- `dec_dest` input 5: destination register (1 for bl).
- `dec_gr_we` input 1: instruction writes the register file.
- `dec_fire` input 1: decode→exe transfer this cycle (`dec_to_exe_valid & exe_allowin`).
- `wb_valid` input 1: write-back stage retiring a valid instruction.
- `wb_we` input 1: that instruction writes the register file.
- `wb_dest` input 5: its destination register.
- `dec_ready_go` output 1: no RAW hazard; decode may proceed.
- `sb_busy` output 1: at least one counter is nonzero.
- `inflight` output 3: total pending writes, sum of all counters, saturating at 7.
- `sb_err` output 1: sticky protocol-error flag.

## Operation
- State: `cnt[1..31]`, each CNT_W bits. r0 has no counter and always reads 0.
- Also holds the `inflight` register and the `sb_err` register.
- inc event = `dec_fire & dec_gr_we & (dec_dest != 0)`; applies to `cnt[dec_dest]`.
- dec event = `wb_valid & wb_we & (wb_dest != 0)`; applies to `cnt[wb_dest]`.
- Same register, inc and dec in the same cycle: counter unchanged, no error.
- Different registers: both updates apply.
- inc while the counter equals MAX_INFLIGHT: counter holds and `sb_err` is set.
- dec while the counter is 0: counter holds at 0 and `sb_err` is set.
- `inflight` changes +1 on inc, −1 on dec, 0 on both or on an errored event.
- hazard_rj = `dec_rj_used & (dec_rj != 0) & (cnt[dec_rj] != 0)`.
- hazard_rkd is the same expression with `dec_rkd`.
- `dec_ready_go = ~(dec_valid & (hazard_rj | hazard_rkd))`, purely combinational from registered counters and the decode inputs.
- `dec_ready_go` does not depend on `dec_fire` or any wb_* input, so no combinational loop is formed.
- A retire in the same cycle as a read does not clear the hazard. The regfile write lands at the edge, so decode sees the value the next cycle. This is correct because there is no forwarding.
- `sb_busy = (inflight != 0)`.
- `sb_err` clears only on reset.
- No flush input: branches resolve in decode, so every issued instruction retires.

## Timing
- Reset values: all `cnt` = 0, `inflight` = 0, `sb_err` = 0.
- Outputs while in reset: `dec_ready_go` = 1, `sb_busy` = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous); in-flight ownership is discarded.
- Counter update takes one cycle: an inc at edge N is visible to the hazard check in cycle N+1.
- Hazard-to-release latency: `dec_ready_go` rises in the cycle after the last matching dec edge.
- For a producer immediately followed by a dependent consumer: producer fires at cycle t, retires in WB at t+3, consumer issues at t+4. The stall is 3 cycles.
- Self-dependence (e.g. `add.w r5,r5,r6`) reads the pre-increment counter, so no stall from itself.
- `dec_ready_go` may toggle while `dec_valid` = 0; downstream gates it with `decode_valid`.

## Test plan
- **Reset:** assert `reset` asynchronously mid-cycle with cnt[4] = 2 → all outputs at reset values before the next edge; `inflight` = 0.
- **Back-to-back RAW:** fire `addi.w r4` at cycle 10, then present `add.w r5,r4,r0` → `dec_ready_go` = 0 in cycles 11–13; dec of r4 at edge 13; `dec_ready_go` = 1 in cycle 14.
- **No hazard:** fire a write to r7, then present a read of r8 and r0 → `dec_ready_go` stays 1; `inflight` = 1.
- **Simultaneous inc/dec, same register:** cnt[3] = 1, fire a write to r3 and retire r3 in the same cycle → cnt[3] stays 1; `inflight` unchanged; `sb_err` = 0.
- **Overflow and underflow:** four fires to r9 with no retire → cnt[9] = 3 and `sb_err` = 1 after the fourth. Separately, from reset, retire r2 → cnt[2] = 0 and `sb_err` = 1.
- **Store/branch source:** fire a write to r6, then present `st.w` with rkd = 6 and `dec_rkd_used` = 1 → stall until r6 retires. With `dec_rkd_used` = 0 → no stall.
